// File: rtl/sum_group_pkg.sv
// Shared width helpers for the sum group accumulator.
package sum_group_pkg;

  function automatic int unsigned cnt_width(int unsigned group_size);
    return $clog2(group_size + 1);
  endfunction

  // Wide enough that group_size items of maximum value cannot overflow.
  function automatic int unsigned acc_width(int unsigned width, int unsigned group_size);
    return width + $clog2(group_size);
  endfunction

endpackage

// File: rtl/sum_group_accumulator_out_reg.sv
// Registered valid/ready output stage; accepts a new word whenever it is empty or draining.
module valid_ready_out_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/sum_group_accumulator.sv
// Sums consecutive stream items into groups of up to GROUP_SIZE, closed early by up_last.
module sum_group_accumulator
  import sum_group_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GROUP_SIZE = 4,
  parameter int unsigned CNT_W      = cnt_width(GROUP_SIZE),
  parameter int unsigned ACC_W      = acc_width(WIDTH, GROUP_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [ACC_W-1:0] down_data,
  output logic [CNT_W-1:0] down_count
);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             accept, closing;

  assign accept  = up_valid && up_ready;
  assign sum     = acc_q + ACC_W'(up_data);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign closing = accept && (up_last || (cnt_inc == CNT_W'(GROUP_SIZE)));

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (closing) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Count and total travel together through one holding register.
  logic [CNT_W+ACC_W-1:0] out_word;

  valid_ready_out_reg #(
    .DW(CNT_W + ACC_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (closing),
    .in_ready (up_ready),
    .in_data  ({cnt_inc, sum}),
    .out_valid(down_valid),
    .out_ready(down_ready),
    .out_data (out_word)
  );

  assign down_count = out_word[CNT_W+ACC_W-1:ACC_W];
  assign down_data  = out_word[ACC_W-1:0];

endmodule

// File: doc/sum_group_accumulator.md
Name: sum_group_accumulator

Overview:
- Downstream consumer of the adder FIFO's sum stream (valid/ready/data).
- Accumulates consecutive sum items into groups of GROUP_SIZE, or fewer when the group is closed early by up_last.
- Emits one wide total plus an item count per group on a registered valid/ready output.
- Sits between the sum FIFO output and the result sink, and applies backpressure upstream when its output is stalled.

Parameters:
- WIDTH, 8, width of each incoming item.
- GROUP_SIZE, 4, maximum number of items per group; must be ≥ 2.
- CNT_W, $clog2(GROUP_SIZE+1), width of the item counter and of down_count.
- ACC_W, WIDTH + $clog2(GROUP_SIZE), width of the accumulator and of down_data.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- up_valid  in  1  input item valid.
- up_ready  out  1  block can accept an input item.
- up_data  in  WIDTH  input item, unsigned.
- up_last  in  1  qualifies up_data; this item closes the current group.
- down_valid  out  1  a group result is held.
- down_ready  in  1  sink accepts the result.
- down_data  out  ACC_W  sum of all items in the group.
- down_count  out  CNT_W  number of items in the group, 1..GROUP_SIZE.

Behaviour:
- Handshakes:
  - Up transfer occurs when up_valid && up_ready.
  - Down transfer occurs when down_valid && down_ready.
  - up_ready = !down_valid || down_ready (combinational). No other combinational input-to-output path exists.
- Reset (asynchronous, any cycle, including mid-group):
  - acc = 0, cnt = 0, down_valid = 0, down_data = 0, down_count = 0.
  - Any partial group is discarded.
- Arithmetic:
  - Unsigned; up_data is zero-extended to ACC_W.
  - ACC_W guarantees no overflow for GROUP_SIZE items of maximum value.
- Non-closing accepted item (up_last == 0 and cnt + 1 < GROUP_SIZE):
  - acc <= acc + up_data; cnt <= cnt + 1.
- Closing accepted item (up_last == 1 or cnt + 1 == GROUP_SIZE):
  - down_data <= acc + up_data; down_count <= cnt + 1; down_valid <= 1.
  - acc <= 0; cnt <= 0.
- Latency: the result is visible one cycle after the closing item is accepted.
- down_valid and held result:
  - down_valid drops the cycle after a down transfer, unless a new closing item is accepted in that same cycle, in which case it stays 1 with the new data.
  - While down_valid && !down_ready: up_ready = 0, and acc, cnt, down_data and down_count are held stable.
- Simultaneous down transfer and up transfer:
  - Both take effect; full throughput of one item per cycle, with no bubble when GROUP_SIZE = 1-style back-to-back closes (up_last every item).
- Idle: with up_valid = 0, state is held. An empty group is never emitted.
- up_last on the GROUP_SIZE-th item: closes once; no extra empty group is produced.

Decomposition:
- Package sum_group_pkg:
  - function acc_width(width, group_size).
  - CNT_W/ACC_W derivation helpers.
- One natural sub-module: valid_ready_out_reg (output holding register with the up_ready = !valid || ready rule).
- Accumulator and counter remain in the top module.

Test Plan:
- Full groups, GROUP_SIZE=4, down_ready=1: items 1,2,3,4,10,20,30,40 → down_data 10 count 4, then 100 count 4, each one cycle after the 4th item.
- Early close: items 5,7 with up_last on 7 → down_data 12 count 2; next items 1,1,1,1 → 4 count 4, proving acc/cnt were cleared.
- Max values: 4 × 255 (WIDTH=8) → down_data 1020 in ACC_W=10 bits, no wrap.
- Backpressure: hold down_ready=0 after a result 10 → up_ready=0 and down_data stable 10 for 5 cycles. Then pulse down_ready=1 with a closing item already waiting → next result appears the following cycle without a bubble.
- Back-to-back singles: up_last=1 on every item 3,4,5 with down_ready=1 → results 3,4,5, each count 1, on consecutive cycles.
- Reset mid-group: after items 9,9, assert rst asynchronously between edges → outputs zero immediately. After release, items 1,2,3,4 → 10 count 4 (the 9s are discarded).
